// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel/line counters with registered sync,
// visible-area and line/frame start flags aligned to the position outputs.
module vga_sync_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int SYNC_POL  = 0,
  parameter int POS_WIDTH = 10
) (
  input  logic                 i_Clk,
  input  logic                 i_Reset,
  input  logic                 i_Clk_En,
  output logic [POS_WIDTH-1:0] o_HSync_Pos,
  output logic [POS_WIDTH-1:0] o_VSync_Pos,
  output logic                 o_HSync,
  output logic                 o_VSync,
  output logic                 o_Active,
  output logic                 o_Line_Start,
  output logic                 o_Frame_Start
);

  typedef logic [POS_WIDTH-1:0] pos_t;

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam pos_t H_LAST = pos_t'(H_TOTAL - 1);
  localparam pos_t V_LAST = pos_t'(V_TOTAL - 1);
  localparam pos_t H_VIS  = pos_t'(H_VISIBLE);
  localparam pos_t V_VIS  = pos_t'(V_VISIBLE);
  localparam pos_t HS_BEG = pos_t'(H_VISIBLE + H_FRONT);
  localparam pos_t HS_END = pos_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam pos_t VS_BEG = pos_t'(V_VISIBLE + V_FRONT);
  localparam pos_t VS_END = pos_t'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam pos_t ONE    = pos_t'(1);

  localparam logic SYNC_ON = (SYNC_POL != 0);

  pos_t h_nxt;
  pos_t v_nxt;
  logic hs_nxt;
  logic vs_nxt;
  logic act_nxt;
  logic ls_nxt;
  logic fs_nxt;

  // Flags are decoded from the next position so they land with it.
  always_comb begin
    h_nxt = o_HSync_Pos + ONE;
    v_nxt = o_VSync_Pos;
    if (o_HSync_Pos == H_LAST) begin
      h_nxt = '0;
      if (o_VSync_Pos == V_LAST) begin
        v_nxt = '0;
      end else begin
        v_nxt = o_VSync_Pos + ONE;
      end
    end
    hs_nxt = (h_nxt >= HS_BEG && h_nxt < HS_END)
             ? SYNC_ON : ~SYNC_ON;
    vs_nxt = (v_nxt >= VS_BEG && v_nxt < VS_END)
             ? SYNC_ON : ~SYNC_ON;
    act_nxt = (h_nxt < H_VIS) && (v_nxt < V_VIS);
    ls_nxt  = (h_nxt == '0);
    fs_nxt  = (h_nxt == '0) && (v_nxt == '0);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      o_HSync_Pos   <= H_LAST;
      o_VSync_Pos   <= V_LAST;
      o_HSync       <= ~SYNC_ON;
      o_VSync       <= ~SYNC_ON;
      o_Active      <= 1'b0;
      o_Line_Start  <= 1'b0;
      o_Frame_Start <= 1'b0;
    end else if (i_Clk_En) begin
      o_HSync_Pos   <= h_nxt;
      o_VSync_Pos   <= v_nxt;
      o_HSync       <= hs_nxt;
      o_VSync       <= vs_nxt;
      o_Active      <= act_nxt;
      o_Line_Start  <= ls_nxt;
      o_Frame_Start <= fs_nxt;
    end
  end

endmodule
